// File: rtl/reg_pipe_multi_ch_sum.sv
// reg_pipe_multi_ch_sum
//   Elastic register pipeline that carries CHANNELS data lanes through DEPTH
//   stages. Each stage has its own valid bit, and a ready chain runs backward
//   through the stages. The output word is the full-precision unsigned sum of
//   the lanes held in the last stage.
//   Optional beat counter: define REG_PIPE_MULTI_CH_SUM_BEAT_CNT_EN to build it.
//   When the macro is undefined, beat_cnt is tied to zero.
module reg_pipe_multi_ch_sum #(
    parameter int DATA_WIDTH = 8,
    parameter int CHANNELS   = 2,
    parameter int DEPTH      = 2,
    parameter int SUM_WIDTH  = DATA_WIDTH + $clog2(CHANNELS),
    parameter int CNT_WIDTH  = 16,
    localparam int OCC_WIDTH = $clog2(DEPTH + 1)
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           flush,
    input  logic [CHANNELS*DATA_WIDTH-1:0] in_data,
    input  logic                           in_vld,
    output logic                           in_rd,
    output logic [SUM_WIDTH-1:0]           out_data,
    output logic                           out_vld,
    input  logic                           out_rd,
    output logic [OCC_WIDTH-1:0]           occupancy,
    output logic [CNT_WIDTH-1:0]           beat_cnt
);

    localparam int LANE_BITS = CHANNELS * DATA_WIDTH;

    // Zero-extend every lane to the sum width before adding, so no carry is lost.
    function automatic logic [SUM_WIDTH-1:0] lane_sum(input logic [LANE_BITS-1:0] d);
        logic [SUM_WIDTH-1:0] acc;
        acc = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            acc = acc + SUM_WIDTH'(d[k*DATA_WIDTH +: DATA_WIDTH]);
        end
        return acc;
    endfunction

    logic [LANE_BITS-1:0] data_q [DEPTH];
    logic [LANE_BITS-1:0] data_d [DEPTH];
    logic [DEPTH-1:0]     vld_q;
    logic [DEPTH-1:0]     vld_d;
    logic [DEPTH:0]       rdy_s;
    logic [OCC_WIDTH-1:0] occ_q;
    logic [OCC_WIDTH-1:0] occ_d;
    logic                 in_xfer_s;
    logic                 out_xfer_s;

    // Ready ripples backward: a stage can load when it is empty or when its successor can load.
    always_comb begin
        rdy_s        = '0;
        rdy_s[DEPTH] = out_rd;
        for (int s = DEPTH - 1; s >= 0; s--) begin
            rdy_s[s] = ~vld_q[s] | rdy_s[s + 1];
        end
    end

    assign in_rd      = rdy_s[0] & ~flush;
    assign in_xfer_s  = in_vld & in_rd;
    assign out_xfer_s = vld_q[DEPTH-1] & out_rd;
    assign out_vld    = vld_q[DEPTH-1];
    assign out_data   = lane_sum(data_q[DEPTH-1]);
    assign occupancy  = occ_q;

    // Stage next-state: ready stages shift in from their predecessor, stalled stages hold, and flush drops every valid.
    always_comb begin
        data_d   = data_q;
        vld_d    = vld_q;
        data_d[0] = rdy_s[0] ? in_data : data_q[0];
        vld_d[0]  = flush ? 1'b0 : (rdy_s[0] ? in_vld : vld_q[0]);
        for (int s = 1; s < DEPTH; s++) begin
            data_d[s] = rdy_s[s] ? data_q[s-1] : data_q[s];
            vld_d[s]  = flush ? 1'b0 : (rdy_s[s] ? vld_q[s-1] : vld_q[s]);
        end
    end

    // Occupancy next-state: follows the transfer handshakes and drops to zero on flush.
    always_comb begin
        occ_d = occ_q;
        if (flush) begin
            occ_d = '0;
        end else begin
            case ({in_xfer_s, out_xfer_s})
                2'b10:   occ_d = occ_q + OCC_WIDTH'(1'b1);
                2'b01:   occ_d = occ_q - OCC_WIDTH'(1'b1);
                default: occ_d = occ_q;
            endcase
        end
    end

    // Stage and occupancy registers; reset empties the pipe and clears the data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < DEPTH; s++) begin
                data_q[s] <= '0;
            end
            vld_q <= '0;
            occ_q <= '0;
        end else begin
            for (int s = 0; s < DEPTH; s++) begin
                data_q[s] <= data_d[s];
            end
            vld_q <= vld_d;
            occ_q <= occ_d;
        end
    end

`ifdef REG_PIPE_MULTI_CH_SUM_BEAT_CNT_EN
    logic [CNT_WIDTH-1:0] cnt_q;
    logic [CNT_WIDTH-1:0] cnt_d;

    // Beat counter next-state: counts output transfers, wraps naturally, and ignores flush.
    always_comb begin
        if (out_xfer_s) begin
            cnt_d = cnt_q + CNT_WIDTH'(1'b1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Beat counter register; only reset clears it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign beat_cnt = cnt_q;
`else
    assign beat_cnt = '0;
`endif

endmodule

// File: tb/tb_reg_pipe_multi_ch_sum.sv
// Self-checking bench for reg_pipe_multi_ch_sum (default parameters).
// Expected sums are queued when an input beat is accepted and compared when the DUT emits an output beat.
module tb_reg_pipe_multi_ch_sum;

    localparam int DW  = 8;
    localparam int CH  = 2;
    localparam int DEP = 2;
    localparam int SW  = DW + $clog2(CH);
    localparam int CW  = 16;
    localparam int OW  = $clog2(DEP + 1);

    logic               clk;
    logic               rst_n;
    logic               flush;
    logic [CH*DW-1:0]   in_data;
    logic               in_vld;
    logic               in_rd;
    logic [SW-1:0]      out_data;
    logic               out_vld;
    logic               out_rd;
    logic [OW-1:0]      occupancy;
    logic [CW-1:0]      beat_cnt;

    int n_vec;
    int n_err;
    logic [SW-1:0] sb[$];
    logic [CW-1:0] cnt_m;

    reg_pipe_multi_ch_sum dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_data   (in_data),
        .in_vld    (in_vld),
        .in_rd     (in_rd),
        .out_data  (out_data),
        .out_vld   (out_vld),
        .out_rd    (out_rd),
        .occupancy (occupancy),
        .beat_cnt  (beat_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [SW-1:0] ref_sum(input logic [CH*DW-1:0] d);
        logic [SW-1:0] acc;
        acc = '0;
        for (int k = 0; k < CH; k++) acc = acc + SW'(d[k*DW +: DW]);
        return acc;
    endfunction

    function automatic logic [CW-1:0] exp_cnt();
`ifdef REG_PIPE_MULTI_CH_SUM_BEAT_CNT_EN
        return cnt_m;
`else
        return '0;
`endif
    endfunction

    // Advance to just after the next rising edge, where stimulus is changed.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor, sampling on the falling edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            sb.delete();
            cnt_m = '0;
        end else begin
            check_eq("occ_vs_inflight", 32'(occupancy), 32'(sb.size()));
            check_eq("beat_cnt", 32'(beat_cnt), 32'(exp_cnt()));
            if (out_vld && out_rd) begin
                if (sb.size() == 0) begin
                    check_eq("unexpected_out", 32'(out_vld), 32'd0);
                end else begin
                    check_eq("out_data", 32'(out_data), 32'(sb.pop_front()));
                end
                cnt_m = cnt_m + 16'd1;
            end
            if (flush) begin
                sb.delete();
            end else if (in_vld && in_rd) begin
                sb.push_back(ref_sum(in_data));
            end
        end
    end

    task automatic drain();
        int i;
        for (i = 0; i < 40; i++) begin
            @(negedge clk);
            if (sb.size() == 0 && !out_vld) break;
        end
        check_eq("drain_done", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        int found;
        int ocnt;
        logic [CW-1:0] bc_before;
        n_vec = 0; n_err = 0; cnt_m = '0;
        rst_n = 1'b0; flush = 1'b0; in_data = '0; in_vld = 1'b0; out_rd = 1'b1;

        // Reset state.
        #12;
        check_eq("rst_out_vld", 32'(out_vld), 32'd0);
        check_eq("rst_occ", 32'(occupancy), 32'd0);
        check_eq("rst_out_data", 32'(out_data), 32'd0);
        check_eq("rst_beat_cnt", 32'(beat_cnt), 32'd0);
        @(negedge clk); #1 rst_n = 1'b1;
        #1 check_eq("rst_in_rd", 32'(in_rd), 32'd1);

        // Latency: one beat {03,05} -> 0x008 two cycles later, occupancy 0,1,1,0.
        tick(); in_data = {8'h03, 8'h05}; in_vld = 1'b1; out_rd = 1'b1;
        @(negedge clk); check_eq("lat_occ0", 32'(occupancy), 32'd0);
        check_eq("lat_in_rd", 32'(in_rd), 32'd1);
        tick(); in_vld = 1'b0;
        @(negedge clk); check_eq("lat_occ1", 32'(occupancy), 32'd1);
        check_eq("lat_vld1", 32'(out_vld), 32'd0);
        tick();
        @(negedge clk); check_eq("lat_occ2", 32'(occupancy), 32'd1);
        check_eq("lat_vld2", 32'(out_vld), 32'd1);
        check_eq("lat_data", 32'(out_data), 32'h008);
        tick();
        @(negedge clk); check_eq("lat_occ3", 32'(occupancy), 32'd0);
        check_eq("lat_vld3", 32'(out_vld), 32'd0);

        // Overflow: FF+FF must not truncate.
        tick(); in_data = {8'hFF, 8'hFF}; in_vld = 1'b1;
        tick(); in_vld = 1'b0;
        found = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (out_vld) begin
                check_eq("ovf_data", 32'(out_data), 32'h1FE);
                found = 1;
                break;
            end
        end
        check_eq("ovf_seen", 32'(found), 32'd1);
        drain();

        // Backpressure: 1,2,3 with out_rd=0; two accepts then full.
        tick(); out_rd = 1'b0; in_vld = 1'b1; in_data = {8'h00, 8'h01};
        @(negedge clk); check_eq("bp_in_rd1", 32'(in_rd), 32'd1);
        tick(); in_data = {8'h00, 8'h02};
        @(negedge clk); check_eq("bp_in_rd2", 32'(in_rd), 32'd1);
        tick(); in_data = {8'h00, 8'h03};
        @(negedge clk); check_eq("bp_in_rd_full", 32'(in_rd), 32'd0);
        check_eq("bp_occ_full", 32'(occupancy), 32'd2);
        tick();
        @(negedge clk); check_eq("bp_hold", 32'(in_rd), 32'd0);
        check_eq("bp_hold_data", 32'(out_data), 32'h001);
        tick(); out_rd = 1'b1;
        @(negedge clk); check_eq("bp_release_in_rd", 32'(in_rd), 32'd1);
        tick(); in_vld = 1'b0;
        @(negedge clk); check_eq("bp_occ_steady", 32'(occupancy), 32'd2);
        drain();

        // Full rate: 10 beats back to back.
        ocnt = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            in_vld = (i < 10);
            in_data = 16'($urandom);
            @(negedge clk);
            if (i < 10) check_eq("fr_in_rd", 32'(in_rd), 32'd1);
            if (i >= 2 && out_vld) ocnt++;
        end
        check_eq("fr_out_count", 32'(ocnt), 32'd10);
        tick(); in_vld = 1'b0;
        drain();

        // Flush with occupancy 2.
        tick(); out_rd = 1'b0; in_vld = 1'b1; in_data = {8'h11, 8'h22};
        tick(); in_data = {8'h33, 8'h44};
        tick(); flush = 1'b1; in_data = {8'h55, 8'h66};
        @(negedge clk); check_eq("fl_occ_pre", 32'(occupancy), 32'd2);
        check_eq("fl_in_rd", 32'(in_rd), 32'd0);
        bc_before = beat_cnt;
        tick(); flush = 1'b0; in_vld = 1'b0;
        @(negedge clk); check_eq("fl_out_vld", 32'(out_vld), 32'd0);
        check_eq("fl_occ", 32'(occupancy), 32'd0);
        check_eq("fl_beat_cnt", 32'(beat_cnt), 32'(bc_before));
        tick(); out_rd = 1'b1;

        // Asynchronous reset mid-stream.
        for (int i = 0; i < 3; i++) begin
            tick(); in_vld = 1'b1; in_data = 16'($urandom);
        end
        tick(); in_vld = 1'b0;
        #2 rst_n = 1'b0;
        #1 check_eq("ar_out_vld", 32'(out_vld), 32'd0);
        check_eq("ar_occ", 32'(occupancy), 32'd0);
        check_eq("ar_beat_cnt", 32'(beat_cnt), 32'd0);
        @(negedge clk); #1 rst_n = 1'b1;
        tick(); in_vld = 1'b1; in_data = {8'h10, 8'h20};
        @(negedge clk); check_eq("ar_lat0", 32'(out_vld), 32'd0);
        tick(); in_vld = 1'b0;
        @(negedge clk); check_eq("ar_lat1", 32'(out_vld), 32'd0);
        tick();
        @(negedge clk); check_eq("ar_lat2", 32'(out_vld), 32'd1);
        check_eq("ar_data", 32'(out_data), 32'h030);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
